// File: rtl/uart_paddle_rx_pkg.sv
// Shared types and constants for the paddle-position UART receive path.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic {WAIT_HI, WAIT_LO} frm_state_t;
   localparam int HDR_BIT = 7;
   localparam int POS_W   = 10;
endpackage

// File: rtl/uart_paddle_rx_if.sv
// Serial line in, decoded paddle position out.
interface uart_paddle_rx_if;
   import uart_pkg::*;
   logic             i_rx;
   logic [POS_W-1:0] o_pos;
   logic             o_valid;
   logic             o_frame_err;

   modport master (output i_rx, input o_pos, o_valid, o_frame_err);
   modport slave  (input i_rx, output o_pos, o_valid, o_frame_err);
endinterface

// File: rtl/uart_paddle_rx_byte.sv
// 8N1 byte receiver: input synchronizer, baud counter, byte FSM and shift register.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic       byte_stb,
   output logic [7:0] byte_data,
   output logic       stop_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic          rx_m, rx_s;
   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          stb_q, stb_d;
   logic          err_q, err_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rx_m    <= i_rx;
         rx_s    <= rx_m;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         stb_q   <= stb_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      stb_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            // A start bit that is gone by mid-bit was a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            // Back to IDLE right at mid-stop so a following start edge is caught.
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s) stb_d = 1'b1;
               else      err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign byte_stb  = stb_q;
   assign byte_data = sh_q;
   assign stop_err  = err_q;
endmodule

// File: rtl/uart_paddle_rx.sv
// Paddle-position receiver: reassembles header/low byte pairs into a 10-bit position.
module uart_paddle_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic             i_clk,
   input  logic             i_rst,
   uart_paddle_rx_if.slave  bus
);
   logic             byte_stb;
   logic [7:0]       byte_data;
   logic             stop_err;

   frm_state_t       frm_q, frm_d;
   logic [2:0]       hi_q, hi_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_rx      (bus.i_rx),
      .byte_stb  (byte_stb),
      .byte_data (byte_data),
      .stop_err  (stop_err)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         frm_q   <= WAIT_HI;
         hi_q    <= '0;
         pos_q   <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         frm_q   <= frm_d;
         hi_q    <= hi_d;
         pos_q   <= pos_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // pos only moves together with valid: the downstream synchronizer shifts on valid.
   always_comb begin
      frm_d   = frm_q;
      hi_d    = hi_q;
      pos_d   = pos_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (stop_err) begin
         ferr_d = 1'b1;
         frm_d  = WAIT_HI;
         hi_d   = '0;
      end else if (byte_stb) begin
         if (byte_data[HDR_BIT]) begin
            if (byte_data[6:3] == 4'd0) begin
               hi_d  = byte_data[2:0];
               frm_d = WAIT_LO;
            end else begin
               ferr_d = 1'b1;
               frm_d  = WAIT_HI;
            end
         end else if (frm_q == WAIT_LO) begin
            pos_d   = {hi_q, byte_data[6:0]};
            valid_d = 1'b1;
            frm_d   = WAIT_HI;
         end else begin
            ferr_d = 1'b1;
         end
      end
   end

   assign bus.o_pos       = pos_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_frame_err = ferr_q;
endmodule

// File: tb/tb_uart_paddle_rx.sv
// Directed bench for uart_paddle_rx at 16 clocks per bit.
module tb_uart_paddle_rx;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_valid = 0, n_err = 0, n_stb = 0, n_both = 0, n_glitch = 0;
   logic [9:0] prev_pos = '0;
   int   v0, e0, s0;

   uart_paddle_rx_if bus ();

   uart_paddle_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Event counters sampled just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         prev_pos = bus.o_pos;
      end else begin
         if (bus.o_valid) n_valid++;
         if (bus.o_frame_err) n_err++;
         if (bus.o_valid && bus.o_frame_err) n_both++;
         if (dut.byte_stb) n_stb++;
         if (bus.o_pos !== prev_pos && !bus.o_valid) n_glitch++;
         prev_pos = bus.o_pos;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      bus.i_rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         bus.i_rx = d[i];
         idle(CPB);
      end
      bus.i_rx = stop;
      idle(CPB);
      bus.i_rx = 1'b1;
   endtask

   task automatic snap();
      v0 = n_valid;
      e0 = n_err;
      s0 = n_stb;
   endtask

   initial begin
      bus.i_rx = 1'b1;
      idle(4);
      rst = 1'b0;
      idle(1);
      chk("reset_pos", 32'(bus.o_pos), 32'h000);
      chk("reset_valid", 32'(bus.o_valid), 32'h0);
      chk("reset_ferr", 32'(bus.o_frame_err), 32'h0);

      // Lone low byte from reset
      snap();
      send_byte(8'h10, 1'b1); idle(48);
      chk("lone_lo_err", 32'(n_err - e0), 32'd1);
      chk("lone_lo_valid", 32'(n_valid - v0), 32'd0);
      chk("lone_lo_pos", 32'(bus.o_pos), 32'h000);

      // Basic frame
      snap();
      send_byte(8'h83, 1'b1); send_byte(8'h25, 1'b1); idle(48);
      chk("frame1_valid", 32'(n_valid - v0), 32'd1);
      chk("frame1_pos", 32'(bus.o_pos), 32'h1A5);
      chk("frame1_err", 32'(n_err - e0), 32'd0);

      // Stop-bit error discards pending header
      snap();
      send_byte(8'h81, 1'b1); send_byte(8'h55, 1'b0); idle(48);
      chk("stoperr_err", 32'(n_err - e0), 32'd1);
      chk("stoperr_valid", 32'(n_valid - v0), 32'd0);
      chk("stoperr_pos_hold", 32'(bus.o_pos), 32'h1A5);
      snap();
      send_byte(8'h80, 1'b1); send_byte(8'h00, 1'b1); idle(48);
      chk("zero_valid", 32'(n_valid - v0), 32'd1);
      chk("zero_pos", 32'(bus.o_pos), 32'h000);

      // Short low glitch is not a start bit
      snap();
      bus.i_rx = 1'b0; idle(5); bus.i_rx = 1'b1; idle(64);
      chk("glitch_stb", 32'(n_stb - s0), 32'd0);
      chk("glitch_err", 32'(n_err - e0), 32'd0);
      chk("glitch_valid", 32'(n_valid - v0), 32'd0);
      send_byte(8'h82, 1'b1); send_byte(8'h01, 1'b1); idle(48);
      chk("post_glitch_pos", 32'(bus.o_pos), 32'h101);
      chk("post_glitch_valid", 32'(n_valid - v0), 32'd1);

      // Back-to-back, second header replaces first
      snap();
      send_byte(8'h81, 1'b1); send_byte(8'h87, 1'b1); send_byte(8'h7F, 1'b1); idle(48);
      chk("b2b_valid", 32'(n_valid - v0), 32'd1);
      chk("b2b_pos", 32'(bus.o_pos), 32'h3FF);
      chk("b2b_err", 32'(n_err - e0), 32'd0);

      // Reset during data bits of the low byte
      send_byte(8'h81, 1'b1);
      bus.i_rx = 1'b0; idle(CPB);
      bus.i_rx = 1'b0; idle(CPB);
      bus.i_rx = 1'b1; idle(CPB);
      rst = 1'b1; idle(1); rst = 1'b0;
      chk("midrst_pos", 32'(bus.o_pos), 32'h000);
      chk("midrst_valid", 32'(bus.o_valid), 32'h0);
      chk("midrst_ferr", 32'(bus.o_frame_err), 32'h0);
      snap();
      idle(300);
      chk("midrst_quiet", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
      send_byte(8'h84, 1'b1); send_byte(8'h0A, 1'b1); idle(48);
      chk("post_rst_pos", 32'(bus.o_pos), 32'h20A);
      chk("post_rst_valid", 32'(n_valid - v0), 32'd1);

      // Line held low: one stop error per byte time, no valid, no lockup
      snap();
      bus.i_rx = 1'b0; idle(800);
      chk("held_low_err", 32'(n_err - e0), 32'd5);
      chk("held_low_valid", 32'(n_valid - v0), 32'd0);
      bus.i_rx = 1'b1; idle(400);
      snap();
      send_byte(8'h83, 1'b1); send_byte(8'h25, 1'b1); idle(48);
      chk("recover_pos", 32'(bus.o_pos), 32'h1A5);
      chk("recover_valid", 32'(n_valid - v0), 32'd1);

      chk("valid_err_overlap", 32'(n_both), 32'd0);
      chk("pos_change_no_valid", 32'(n_glitch), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_paddle_rx.md
# uart_paddle_rx

Serial front end for the paddle-position path. Receives 8N1 UART bytes on a single RX pin, reassembles two-byte position frames, and presents a 10-bit position with a one-cycle valid strobe. Its `o_pos`/`o_valid` pair drives the double-flop position synchronizer that feeds the renderer. Malformed bytes and frames are dropped and flagged; they never reach `o_pos`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104 (12 MHz / 115200). Clock cycles per UART bit; must be ≥ 4.

Ports:
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_rx`  in  1  asynchronous UART line; idles high.
- `o_pos`  out  10  last complete paddle position; holds between updates.
- `o_valid`  out  1  one-cycle pulse when `o_pos` has just been updated.
- `o_frame_err`  out  1  one-cycle pulse on a dropped byte or frame.

## Operation
- **RX input:** `i_rx` passes through 2 flops that reset to 1. All logic uses the synced signal `rx_s`.

**Byte receiver FSM (IDLE, START, DATA, STOP):**
- IDLE → START when `rx_s` = 0; clear the baud counter.
- START: at count `CLKS_PER_BIT/2` (floor), check `rx_s`.
  - If 0: go to DATA and reset the counter.
  - If 1: it was a glitch; return to IDLE and emit nothing.
- DATA: sample `rx_s` every `CLKS_PER_BIT` cycles, so each sample lands mid-bit. Shift in LSB first. After the 8th sample, go to STOP.
- STOP: one bit-period after the last data sample, sample the stop bit.
  - If 1: emit `byte_stb` with `byte_data`.
  - If 0: emit `stop_err`.
  - Either way, return to IDLE that cycle, so a new start bit is accepted immediately.
- Baud counter width is `$clog2(CLKS_PER_BIT)`.

**Frame protocol:**
- Header byte: bit7 = 1, bits[6:3] = 0, bits[2:0] = pos[9:7].
- Low byte: bit7 = 0, bits[6:0] = pos[6:0].

**Frame assembler FSM (WAIT_HI, WAIT_LO):**
- Valid header in any state: latch `hi` ← bits[2:0] and go to WAIT_LO. A new header replaces any pending one.
- Header with bits[6:3] ≠ 0: pulse `o_frame_err` and go to WAIT_HI.
- Low byte in WAIT_LO: `o_pos` ← {`hi`, byte[6:0]}, pulse `o_valid`, go to WAIT_HI.
- Low byte in WAIT_HI: drop it and pulse `o_frame_err`.
- `stop_err` in any state: pulse `o_frame_err`, go to WAIT_HI, discard the pending `hi`.
- `o_valid` and `o_frame_err` are never high in the same cycle.

## Timing
- Reset values:
  - `o_pos` = 0, `o_valid` = 0, `o_frame_err` = 0.
  - Sync flops = 1, shift register = 0, `hi` = 0.
  - Byte FSM = IDLE, assembler = WAIT_HI.
- Reset mid-byte or mid-frame aborts all progress. The first full frame after reset release decodes normally.
- `byte_stb` / `stop_err` is registered in the cycle the stop bit is sampled.
- `o_valid` / `o_frame_err` follows 1 cycle after `byte_stb` / `stop_err`.
- Latency from the line's mid-stop-bit to `o_valid` is 2 sync cycles + 1 + 1.
- `o_pos` changes only in the cycle `o_valid` is high. This is required because the downstream synchronizer shifts only on valid.
- Back-to-back bytes with no idle gap are supported, as is a line held low indefinitely. In the held-low case each "byte" fails its stop bit, producing one `o_frame_err` per byte time with no lockup.

## Structure
- `uart_pkg`:
  - `rx_state_t` (IDLE, START, DATA, STOP)
  - `frm_state_t` (WAIT_HI, WAIT_LO)
  - `HDR_BIT` = 7, `POS_W` = 10
- Sub-module `uart_rx_byte` holds the sync flops, baud counter, byte FSM and shift register. Its outputs are `byte_stb`, `byte_data[7:0]` and `stop_err`.
- Top `uart_paddle_rx` instantiates `uart_rx_byte` and holds the assembler FSM and output registers.

## Test plan
Use `CLKS_PER_BIT` = 16 and a behavioural UART driver.
- Send 0x83, 0x25 → exactly one `o_valid`; `o_pos` = 0x1A5; `o_frame_err` never asserted.
- From reset, send a lone 0x10 → one `o_frame_err` pulse, no `o_valid`, `o_pos` stays 0x000.
- Send 0x81, then 0x55 with its stop bit forced 0 → `o_frame_err`, no `o_valid`. Then send 0x80, 0x00 → `o_valid` with `o_pos` = 0x000.
- Drive `i_rx` low for 5 cycles (< 8), then high → no `byte_stb`, no outputs. A following 0x82, 0x01 → `o_pos` = 0x101.
- Send 0x81, 0x87, 0x7F back-to-back with no gap → exactly one `o_valid`; `o_pos` = 0x3FF.
- Assert `i_rst` for 1 cycle during the DATA bits of a low byte → all outputs 0. The next 0x84, 0x0A → `o_pos` = 0x20A.
